// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler that drives the select of a shared 6:1 result mux.
// Latency: req sampled at edge k -> sel/gnt after edge k; out_valid and ack are combinational in GRANT.
// Backpressure: out_ready low holds the grant and the beat count; a source dropping its req releases the grant.
module mux_rr_scheduler #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       req,
    input  logic             out_ready,
    output logic [2:0]       sel,
    output logic [5:0]       gnt,
    output logic             out_valid,
    output logic [5:0]       ack,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, sel_d;
    logic [5:0]        gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cur_req;
    logic              beat;
    logic              last_beat;
    logic              release_grant;
    logic [2:0]        ptr_wrap;
    logic [2:0]        arb_start;
    logic              arb_found;
    logic [2:0]        arb_win;
    logic [3:0]        arb_sum;
    logic [2:0]        arb_idx;

    // Beat acceptance and release conditions for the source currently selected.
    always_comb begin
        cur_req       = req[sel_q];
        out_valid     = (state_q == GRANT) && cur_req;
        beat          = out_valid && out_ready;
        ack           = beat ? gnt_q : 6'b0;
        last_beat     = (cnt_q == CNT_W'(MAX_BURST - 1));
        release_grant = (state_q == GRANT) && (!cur_req || (beat && last_beat));
        ptr_wrap      = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
        arb_start     = release_grant ? ptr_wrap : ptr_q;
    end

    // Search upward from arb_start with wrap 5 -> 0; the first set request wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = arb_start;
        arb_sum   = 4'd0;
        arb_idx   = 3'd0;
        for (int k = 0; k < 6; k++) begin
            arb_sum = {1'b0, arb_start} + 4'(k);
            if (arb_sum >= 4'd6) begin
                arb_sum = arb_sum - 4'd6;
            end
            arb_idx = arb_sum[2:0];
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    sel_d   = arb_win;
                    gnt_d   = 6'b1 << arb_win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    gnt_d   = 6'b0;
                    busy_d  = 1'b0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    ptr_d = ptr_wrap;
                    if (arb_found) begin
                        // Back-to-back grant: no idle bubble between bursts.
                        sel_d = arb_win;
                        gnt_d = 6'b1 << arb_win;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 6'b0;
                        busy_d  = 1'b0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 6'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            gnt_q   <= 6'b0;
            busy_q  <= 1'b0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler (MAX_BURST=4): vector table plus multi-cycle sequences.
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [5:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [5:0] gnt;
    logic       out_valid;
    logic [5:0] ack;
    logic       busy;

    int n_chk;
    int n_fail;

    mux_rr_scheduler #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [5:0] req;
        logic       rdy;
        logic [2:0] sel;
        logic [5:0] gnt;
        logic       busy;
        logic       ov;
        logic [5:0] ack;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int e_sel, input int e_gnt, input int e_busy,
                           input int e_ov, input int e_ack);
        chk({tag, ".sel"}, int'(sel), e_sel);
        chk({tag, ".gnt"}, int'(gnt), e_gnt);
        chk({tag, ".busy"}, int'(busy), e_busy);
        chk({tag, ".out_valid"}, int'(out_valid), e_ov);
        chk({tag, ".ack"}, int'(ack), e_ack);
    endtask

    // Leaves the DUT idle at a falling edge with rst_n high and req cleared.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 6'h00; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic [5:0] r, input logic rdy);
        @(negedge clk);
        req = r; out_ready = rdy;
        #1;
    endtask

    initial begin
        int acks;
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; req = 6'h00; out_ready = 1'b0;

        //            rst   req    rdy   sel   gnt    busy  ov    ack
        tbl[0]  = '{1'b0, 6'h3F, 1'b1, 3'd0, 6'h00, 1'b0, 1'b0, 6'h00};
        tbl[1]  = '{1'b1, 6'h00, 1'b1, 3'd0, 6'h00, 1'b0, 1'b0, 6'h00};
        tbl[2]  = '{1'b1, 6'h04, 1'b1, 3'd0, 6'h00, 1'b0, 1'b0, 6'h00};
        tbl[3]  = '{1'b1, 6'h04, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};
        tbl[4]  = '{1'b1, 6'h04, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};
        tbl[5]  = '{1'b1, 6'h04, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};
        tbl[6]  = '{1'b1, 6'h04, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};
        tbl[7]  = '{1'b1, 6'h04, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};
        tbl[8]  = '{1'b1, 6'h04, 1'b0, 3'd2, 6'h04, 1'b1, 1'b1, 6'h00};
        tbl[9]  = '{1'b1, 6'h00, 1'b1, 3'd2, 6'h04, 1'b1, 1'b0, 6'h00};
        tbl[10] = '{1'b1, 6'h00, 1'b1, 3'd2, 6'h00, 1'b0, 1'b0, 6'h00};
        tbl[11] = '{1'b1, 6'h01, 1'b1, 3'd2, 6'h00, 1'b0, 1'b0, 6'h00};
        tbl[12] = '{1'b1, 6'h05, 1'b1, 3'd0, 6'h01, 1'b1, 1'b1, 6'h01};
        tbl[13] = '{1'b1, 6'h04, 1'b1, 3'd0, 6'h01, 1'b1, 1'b0, 6'h00};
        tbl[14] = '{1'b1, 6'h3F, 1'b1, 3'd2, 6'h04, 1'b1, 1'b1, 6'h04};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; req = tbl[i].req; out_ready = tbl[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), int'(tbl[i].sel), int'(tbl[i].gnt),
                    int'(tbl[i].busy), int'(tbl[i].ov), int'(tbl[i].ack));
        end

        // Fairness and wrap: every source in turn, 4 beats each.
        do_reset();
        req = 6'h3F; out_ready = 1'b1;
        acks = 0;
        for (int c = 0; c < 28; c++) begin
            cyc(6'h3F, 1'b1);
            chk($sformatf("rr%0d.sel", c), int'(sel), (c / 4) % 6);
            chk($sformatf("rr%0d.ack", c), int'(ack), 1 << ((c / 4) % 6));
            if (c < 24 && ack != 6'h00) acks++;
        end
        chk("rr.acks_per_rotation", acks, 24);

        // Backpressure after beat 2; beats 3 and 4 complete the burst, then source 2 wins.
        do_reset();
        req = 6'h06; out_ready = 1'b1;
        cyc(6'h06, 1'b1); chk_all("bp.b1", 1, 6'h02, 1, 1, 6'h02);
        cyc(6'h06, 1'b1); chk_all("bp.b2", 1, 6'h02, 1, 1, 6'h02);
        for (int c = 0; c < 3; c++) begin
            cyc(6'h06, 1'b0); chk_all($sformatf("bp.stall%0d", c), 1, 6'h02, 1, 1, 6'h00);
        end
        cyc(6'h06, 1'b1); chk_all("bp.b3", 1, 6'h02, 1, 1, 6'h02);
        cyc(6'h06, 1'b1); chk_all("bp.b4", 1, 6'h02, 1, 1, 6'h02);
        cyc(6'h06, 1'b1); chk_all("bp.next", 2, 6'h04, 1, 1, 6'h04);

        // Drop after 2 beats hands over to source 4 with a fresh beat count.
        do_reset();
        req = 6'h12; out_ready = 1'b1;
        cyc(6'h12, 1'b1); chk_all("drop.b1", 1, 6'h02, 1, 1, 6'h02);
        cyc(6'h12, 1'b1); chk_all("drop.b2", 1, 6'h02, 1, 1, 6'h02);
        cyc(6'h10, 1'b1); chk_all("drop.fall", 1, 6'h02, 1, 0, 6'h00);
        for (int c = 0; c < 4; c++) begin
            cyc(6'h12, 1'b1); chk_all($sformatf("drop.s4b%0d", c), 4, 6'h10, 1, 1, 6'h10);
        end
        cyc(6'h12, 1'b1); chk_all("drop.back1", 1, 6'h02, 1, 1, 6'h02);

        // Asynchronous reset pulse between edges mid-burst.
        do_reset();
        req = 6'h04; out_ready = 1'b1;
        cyc(6'h04, 1'b1); chk_all("arst.pre", 2, 6'h04, 1, 1, 6'h04);
        #1 rst_n = 1'b0;
        #1;
        chk_all("arst.during", 0, 6'h00, 0, 0, 6'h00);
        #1 rst_n = 1'b1; req = 6'h3F;
        cyc(6'h3F, 1'b1); chk_all("arst.after", 0, 6'h01, 1, 1, 6'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that shares the 6-to-1, 8-bit result mux between six requesters. It arbitrates the `req` lines and drives the mux `sel` input. It grants bursts of up to `MAX_BURST` beats under a valid/ready handshake and returns a per-requester `ack` for every beat accepted downstream. The mux itself stays combinational; this block supplies all sequencing.

## Interface
- `MAX_BURST`, 4: maximum beats per grant; legal range 1..15.
- `CNT_W`, 4: width of the internal beat counter; must hold `MAX_BURST-1`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  6  request per source `d0..d5`; bit i high means source i has a beat on `di`.
- `out_ready`  in  1  downstream can take the mux result `res` this cycle.
- `sel`  out  3  mux select, registered; only values 0..5 are driven.
- `gnt`  out  6  one-hot grant, registered; `gnt[i]` equals (`sel`==i) while busy.
- `out_valid`  out  1  `res` is valid this cycle (combinational).
- `ack`  out  6  beat of source i accepted this cycle (combinational).
- `busy`  out  1  a grant is held (registered).

## Operation
- States: IDLE, GRANT. Internal registers: `ptr` (3 bits, 0..5), `beat_cnt` (`CNT_W` bits).
- Arbitration function: search for the first set `req` bit starting at `ptr` and moving upward, wrapping from 5 to 0.
- IDLE, any `req` set: the winner w is loaded into `sel`, `gnt` becomes `1<<w`, `busy` goes to 1, `beat_cnt` goes to 0, and the next state is GRANT.
- IDLE, no `req` set: remain in IDLE; `gnt`=0, `busy`=0, `sel` holds its last value.
- GRANT outputs:
  - `out_valid` = `req[sel]`.
  - beat = `out_valid & out_ready`.
  - `ack` = `gnt` when beat is high, else 0.
- GRANT, beat with `beat_cnt` < `MAX_BURST-1`: increment `beat_cnt`.
- GRANT, no beat while `req[sel]` is high (backpressure): hold all state.
- Release occurs on either of these conditions:
  - burst end: beat with `beat_cnt`==`MAX_BURST-1`;
  - drop: `req[sel]`==0.
- On release:
  - `ptr` becomes `sel+1`, with 5 wrapping to 0.
  - Re-arbitrate on the same edge using the new `ptr`. The current source has lowest priority but can be re-granted if it is the only requester.
  - If there is a winner: stay in GRANT, load the new `sel`/`gnt`, and clear `beat_cnt`. No idle cycle is inserted.
  - If there is no winner: go to IDLE with `gnt`=0 and `busy`=0.
- `sel` and `gnt` never change while in GRANT except on release.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately): state=IDLE, `sel`=0, `gnt`=0, `busy`=0, `ptr`=0, `beat_cnt`=0. Consequently `out_valid`=0 and `ack`=0.
- Reset mid-burst aborts the burst with no `ack`. After reset release, arbitration restarts at `ptr`=0.
- Latency from `req` to `out_valid`: `req` sampled at edge k gives `gnt`/`sel` after edge k, and `out_valid` is high in cycle k+1.
- A full burst with `out_ready` held at 1 occupies `MAX_BURST` consecutive cycles. The next grant's first beat follows in the immediately next cycle.
- `ack` asserts in the same cycle as the accepted beat. The source may drop or change `req`/`di` after that edge.
- `req[sel]` falling with `out_ready`=1 in the same cycle: no beat and no `ack`. This is a drop release at that edge.
- `MAX_BURST`=1 gives a strict one-beat round-robin.

## Test plan
- Reset check: `rst_n`=0 with `req`=6'h3F → `sel`=0, `gnt`=0, `busy`=0, `out_valid`=0, `ack`=0. Pulse `rst_n` low between edges mid-burst → all outputs clear immediately. After release, first grant goes to source 0.
- Single requester: `req`=6'h04, `out_ready`=1, `MAX_BURST`=4 → `gnt`=6'h04, `sel`=2, four `ack`=6'h04 beats. Source 2 is then re-granted with no gap and `beat_cnt` restarts; `res` equals `d2` whenever `out_valid` is high.
- Fairness and wrap: `req`=6'h3F, `out_ready`=1 → `sel` sequence 0,1,2,3,4,5,0, each held 4 cycles, with 24 acks per full rotation.
- Backpressure: `req`=6'h02, `out_ready`=0 for 3 cycles after beat 2 → `gnt`=6'h02 stable, `ack`=0, and the burst completes with beats 3 and 4 once `out_ready` returns to 1.
- Drop: source 1 granted, `req[1]` falls after 2 beats while `req[4]`=1 → next edge `sel`=4, `gnt`=6'h10, `beat_cnt`=0.
- Idle return: the sole requester drops with `req`=0 → next edge `busy`=0, `gnt`=0, and `sel` holds its last value. New `req`=6'h01 → grant to 0, then to 2 on the next release if `req[2]` is set.
